// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage RV32 core.
// The block tracks EX/MEM/WB in a small shadow pipeline. From that state it
// drives the datapath register enables and bubbles, the EX forwarding muxes
// and the stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned RF_ADDRESS = 5,
    parameter int unsigned MC_LAT     = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  id_multicycle,
    input  logic                  ex_redirect,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_bubble,
    output logic                  mem_wb_bubble,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned McW = $clog2(MC_LAT) + 1;
    localparam logic [McW-1:0] McLoad = McW'(MC_LAT - 1);

    typedef struct packed {
        logic                  valid;
        logic [RF_ADDRESS-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic                  memop;
    } stage_t;

    stage_t                ex_q, ex_d, mem_q, mem_d;
    logic [RF_ADDRESS-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    // WB only ever feeds the forwarding compare, so memory bits are not kept.
    logic                  wb_valid_q, wb_valid_d, wb_regwrite_q, wb_regwrite_d;
    logic [RF_ADDRESS-1:0] wb_rd_q, wb_rd_d;
    logic [McW-1:0]        mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic mem_stall, mc_busy, load_use, redirect_apply;
    logic mem_fwd_ok, wb_fwd_ok;

    assign mem_stall = mem_q.valid & mem_q.memop & ~dmem_ready;
    assign mc_busy   = (mc_cnt_q != '0);
    assign load_use  = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid &
                       ((id_use_rs1 & (id_rs1 == ex_q.rd)) |
                        (id_use_rs2 & (id_rs2 == ex_q.rd)));

    // Prioritised hazard resolution into register enables and bubbles.
    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        id_ex_en       = 1'b1;
        ex_mem_en      = 1'b1;
        mem_wb_en      = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_mem_bubble  = 1'b0;
        mem_wb_bubble  = 1'b0;
        redirect_apply = 1'b0;
        if (!reset) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (mc_busy) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
        end else if (ex_redirect) begin
            // Redirect only lands in a cycle where EX moves on.
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            redirect_apply = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Shadow pipeline follows exactly the enables/bubbles sent to the datapath.
    always_comb begin
        ex_d          = ex_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        mem_d         = mem_q;
        wb_valid_d    = wb_valid_q;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = wb_regwrite_q;
        if (id_ex_en) begin
            if (id_ex_bubble) begin
                ex_d     = '0;
                ex_rs1_d = '0;
                ex_rs2_d = '0;
            end else begin
                ex_d.valid    = id_valid;
                ex_d.rd       = id_rd;
                ex_d.regwrite = id_regwrite;
                ex_d.memread  = id_memread;
                ex_d.memop    = id_memread | id_memwrite;
                ex_rs1_d      = id_rs1;
                ex_rs2_d      = id_rs2;
            end
        end
        if (ex_mem_en) begin
            mem_d = ex_mem_bubble ? '0 : ex_q;
        end
        if (mem_wb_en) begin
            wb_valid_d    = mem_wb_bubble ? 1'b0 : mem_q.valid;
            wb_rd_d       = mem_wb_bubble ? '0 : mem_q.rd;
            wb_regwrite_d = mem_wb_bubble ? 1'b0 : mem_q.regwrite;
        end
    end

    // Multi-cycle countdown; loads only when a real instruction enters EX.
    always_comb begin
        mc_cnt_d = mc_cnt_q;
        if (mc_busy) begin
            if (!mem_stall) begin
                mc_cnt_d = mc_cnt_q - McW'(1);
            end
        end else if (id_ex_en && !id_ex_bubble && id_valid && id_multicycle) begin
            mc_cnt_d = McLoad;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset && !pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_apply && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q          <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            mem_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
            mc_cnt_q      <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_q          <= ex_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            mem_q         <= mem_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            mc_cnt_q      <= mc_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    // Loads in MEM have no data yet, so MEM forwards only ALU results.
    assign mem_fwd_ok = mem_q.valid & mem_q.regwrite & ~mem_q.memread & (mem_q.rd != '0);
    assign wb_fwd_ok  = wb_valid_q & wb_regwrite_q & (wb_rd_q != '0);

    // Operand forwarding select, MEM before WB.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (reset) begin
            if (mem_fwd_ok && (mem_q.rd == ex_rs1_q)) begin
                fwd_a_sel = 2'b10;
            end else if (wb_fwd_ok && (wb_rd_q == ex_rs1_q)) begin
                fwd_a_sel = 2'b01;
            end
            if (mem_fwd_ok && (mem_q.rd == ex_rs2_q)) begin
                fwd_b_sel = 2'b10;
            end else if (wb_fwd_ok && (wb_rd_q == ex_rs2_q)) begin
                fwd_b_sel = 2'b01;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (MC_LAT=4/CNT_W=16 and
// MC_LAT=1/CNT_W=2) share one stimulus stream and are each checked against a
// slot-level pipeline model every cycle, plus directed scenario checks.
module tb_pipe_hazard_ctrl;

    typedef logic [4:0] reg_t;
    typedef struct packed {
        logic v;
        reg_t rd;
        logic rw;
        logic mr;
        logic mo;
        reg_t rs1;
        reg_t rs2;
    } slot_t;

    localparam int A_RST = 0, A_MS = 1, A_MC = 2, A_RD = 3, A_LU = 4, A_NO = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, id_valid, id_use_rs1, id_use_rs2;
    logic id_regwrite, id_memread, id_memwrite, id_multicycle, ex_redirect, dmem_ready;
    reg_t id_rs1, id_rs2, id_rd;

    logic pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, mem_wb_en0;
    logic if_id_flush0, id_ex_bubble0, ex_mem_bubble0, mem_wb_bubble0;
    logic pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1;
    logic if_id_flush1, id_ex_bubble1, ex_mem_bubble1, mem_wb_bubble1;
    logic [1:0] fwd_a0, fwd_b0, fwd_a1, fwd_b1;
    logic [15:0] stall0, flush0;
    logic [1:0] stall1, flush1;
    logic [8:0] ctl0, ctl1;

    assign ctl0 = {pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, mem_wb_en0,
                   if_id_flush0, id_ex_bubble0, ex_mem_bubble0, mem_wb_bubble0};
    assign ctl1 = {pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1,
                   if_id_flush1, id_ex_bubble1, ex_mem_bubble1, mem_wb_bubble1};

    pipe_hazard_ctrl #(.RF_ADDRESS(5), .MC_LAT(4), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_multicycle(id_multicycle), .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
        .pc_en(pc_en0), .if_id_en(if_id_en0), .id_ex_en(id_ex_en0), .ex_mem_en(ex_mem_en0),
        .mem_wb_en(mem_wb_en0), .if_id_flush(if_id_flush0), .id_ex_bubble(id_ex_bubble0),
        .ex_mem_bubble(ex_mem_bubble0), .mem_wb_bubble(mem_wb_bubble0),
        .fwd_a_sel(fwd_a0), .fwd_b_sel(fwd_b0), .stall_cnt(stall0), .flush_cnt(flush0)
    );

    pipe_hazard_ctrl #(.RF_ADDRESS(5), .MC_LAT(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_multicycle(id_multicycle), .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
        .pc_en(pc_en1), .if_id_en(if_id_en1), .id_ex_en(id_ex_en1), .ex_mem_en(ex_mem_en1),
        .mem_wb_en(mem_wb_en1), .if_id_flush(if_id_flush1), .id_ex_bubble(id_ex_bubble1),
        .ex_mem_bubble(ex_mem_bubble1), .mem_wb_bubble(mem_wb_bubble1),
        .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1), .stall_cnt(stall1), .flush_cnt(flush1)
    );

    // Reference model: instructions as slots moving EX -> MEM -> WB.
    slot_t m_ex[2], m_mem[2], m_wb[2];
    int    m_left[2], m_stall[2], m_flush[2];
    int    act[2];
    int    total = 0, bad = 0;

    function automatic int lat_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int cmax_of(int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    function automatic int decide(int k);
        logic lu;
        lu = m_ex[k].v && m_ex[k].mr && (m_ex[k].rd != 0) && id_valid &&
             ((id_use_rs1 && id_rs1 == m_ex[k].rd) || (id_use_rs2 && id_rs2 == m_ex[k].rd));
        if (!reset) return A_RST;
        if (m_mem[k].v && m_mem[k].mo && !dmem_ready) return A_MS;
        if (m_left[k] > 0) return A_MC;
        if (ex_redirect) return A_RD;
        if (lu) return A_LU;
        return A_NO;
    endfunction

    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex/ex_mem/mem_wb bubbles}
    function automatic logic [8:0] ctl_exp(int a);
        case (a)
            A_RST:   return 9'b00000_1111;
            A_MS:    return 9'b00001_0001;
            A_MC:    return 9'b00011_0010;
            A_RD:    return 9'b11111_1100;
            A_LU:    return 9'b00111_0100;
            default: return 9'b11111_0000;
        endcase
    endfunction

    function automatic logic [1:0] fwd_exp(int k, reg_t rs);
        if (!reset) return 2'b00;
        if (m_mem[k].v && m_mem[k].rw && !m_mem[k].mr && m_mem[k].rd != 0 && m_mem[k].rd == rs)
            return 2'b10;
        if (m_wb[k].v && m_wb[k].rw && m_wb[k].rd != 0 && m_wb[k].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) act[k] = decide(k);
        chk("ctl0", 32'(ctl0), 32'(ctl_exp(act[0])));
        chk("fwd_a0", 32'(fwd_a0), 32'(fwd_exp(0, m_ex[0].rs1)));
        chk("fwd_b0", 32'(fwd_b0), 32'(fwd_exp(0, m_ex[0].rs2)));
        chk("stall_cnt0", 32'(stall0), 32'(m_stall[0]));
        chk("flush_cnt0", 32'(flush0), 32'(m_flush[0]));
        chk("ctl1", 32'(ctl1), 32'(ctl_exp(act[1])));
        chk("fwd_a1", 32'(fwd_a1), 32'(fwd_exp(1, m_ex[1].rs1)));
        chk("fwd_b1", 32'(fwd_b1), 32'(fwd_exp(1, m_ex[1].rs2)));
        chk("stall_cnt1", 32'(stall1), 32'(m_stall[1]));
        chk("flush_cnt1", 32'(flush1), 32'(m_flush[1]));
    endtask

    task automatic step();
        slot_t ids;
        ids = {id_valid, id_rd, id_regwrite, id_memread, id_memread | id_memwrite, id_rs1, id_rs2};
        for (int k = 0; k < 2; k++) begin
            case (act[k])
                A_RST: begin
                    m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
                    m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
                end
                A_MS: begin
                    m_wb[k] = '0;
                    if (m_stall[k] < cmax_of(k)) m_stall[k]++;
                end
                A_MC: begin
                    m_wb[k] = m_mem[k]; m_mem[k] = '0; m_left[k]--;
                    if (m_stall[k] < cmax_of(k)) m_stall[k]++;
                end
                A_RD: begin
                    m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = '0;
                    if (m_flush[k] < cmax_of(k)) m_flush[k]++;
                end
                A_LU: begin
                    m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = '0;
                    if (m_stall[k] < cmax_of(k)) m_stall[k]++;
                end
                default: begin
                    m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = ids;
                    if (id_valid && id_multicycle) m_left[k] = lat_of(k) - 1;
                end
            endcase
        end
    endtask

    task automatic drive(input logic v, input reg_t rs1, input reg_t rs2, input logic u1,
                         input logic u2, input reg_t rd, input logic rw, input logic mr,
                         input logic mw, input logic mc, input logic redir, input logic rdy);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
        id_multicycle = mc; ex_redirect = redir; dmem_ready = rdy;
    endtask

    task automatic nop(input logic redir, input logic rdy);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, redir, rdy);
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic adv();
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    initial begin
        logic prev_redir;
        // First reset edge: DUT state is unknown before it, so no check yet.
        reset = 1'b0;
        nop(1'b0, 1'b1);
        @(posedge clk);
        #1;
        act[0] = A_RST; act[1] = A_RST;
        step();
        settle();
        chk("rst_if_id_flush", 32'(if_id_flush0), 32'd1);
        adv();
        reset = 1'b1;

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        drive(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0, 0, 1); cyc();
        drive(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, 0, 1); settle();
        chk("lu_pc_en", 32'(pc_en0), 32'd0);
        chk("lu_id_ex_bubble", 32'(id_ex_bubble0), 32'd1);
        chk("lu_stall_before", 32'(stall0), 32'd0);
        adv();
        settle();
        chk("lu_stall_after", 32'(stall0), 32'd1);
        chk("lu_pc_en_resume", 32'(pc_en0), 32'd1);
        adv();
        nop(0, 1); settle();
        chk("lu_fwd_wb", 32'(fwd_a0), 32'd1);
        adv();

        // MEM beats WB; x0 never forwarded.
        drive(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 1); cyc();
        drive(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 1); cyc();
        drive(1, 5'd3, 5'd3, 1, 1, 5'd7, 1, 0, 0, 0, 0, 1); cyc();
        nop(0, 1); settle();
        chk("fwd_mem_a", 32'(fwd_a0), 32'd2);
        chk("fwd_mem_b", 32'(fwd_b0), 32'd2);
        adv();
        drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 0, 1); cyc();
        drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 0, 1); cyc();
        drive(1, 5'd0, 5'd0, 1, 1, 5'd8, 1, 0, 0, 0, 0, 1); cyc();
        nop(0, 1); settle();
        chk("fwd_x0", 32'(fwd_a0), 32'd0);
        adv();

        // Load in MEM, dmem_ready low for three cycles.
        drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 0, 0, 0, 1); cyc();
        nop(0, 1); cyc();
        for (int i = 0; i < 3; i++) begin
            nop(0, 0); settle();
            chk("ms_pc_en", 32'(pc_en0), 32'd0);
            chk("ms_ex_mem_en", 32'(ex_mem_en0), 32'd0);
            chk("ms_mem_wb_bubble", 32'(mem_wb_bubble0), 32'd1);
            adv();
        end
        nop(0, 1); settle();
        chk("ms_stall_cnt", 32'(stall0), 32'd4);
        chk("ms_sat_stall_cnt1", 32'(stall1), 32'd3);
        chk("ms_resume_pc_en", 32'(pc_en0), 32'd1);
        adv();

        // Multi-cycle op: three frozen cycles at MC_LAT=4, none at MC_LAT=1.
        drive(1, 5'd1, 5'd2, 1, 1, 5'd10, 1, 0, 0, 1, 0, 1); cyc();
        for (int i = 0; i < 3; i++) begin
            nop(0, 1); settle();
            chk("mc_pc_en0", 32'(pc_en0), 32'd0);
            chk("mc_ex_mem_bubble0", 32'(ex_mem_bubble0), 32'd1);
            chk("mc_pc_en1", 32'(pc_en1), 32'd1);
            adv();
        end
        nop(0, 1); settle();
        chk("mc_done_pc_en0", 32'(pc_en0), 32'd1);
        adv();

        // Redirect together with load-use: redirect wins.
        drive(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0, 0, 1); cyc();
        drive(1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 0, 1, 1); settle();
        chk("rd_if_id_flush", 32'(if_id_flush0), 32'd1);
        chk("rd_id_ex_bubble", 32'(id_ex_bubble0), 32'd1);
        chk("rd_pc_en", 32'(pc_en0), 32'd1);
        adv();
        nop(0, 1); settle();
        chk("rd_flush_cnt", 32'(flush0), 32'd1);
        adv();

        // Redirect held through a memory stall lands on the ready cycle.
        drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 0, 0, 0, 1); cyc();
        nop(0, 1); cyc();
        for (int i = 0; i < 2; i++) begin
            nop(1, 0); settle();
            chk("msr_no_flush", 32'(if_id_flush0), 32'd0);
            adv();
        end
        nop(1, 1); settle();
        chk("msr_flush", 32'(if_id_flush0), 32'd1);
        adv();
        nop(0, 1); settle();
        chk("msr_flush_cnt", 32'(flush0), 32'd2);
        adv();

        // Reset in the middle of a memory stall.
        drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 1, 0, 0, 0, 1); cyc();
        nop(0, 1); cyc();
        nop(0, 0); cyc();
        reset = 1'b0;
        nop(0, 0); settle();
        chk("rst_pc_en", 32'(pc_en0), 32'd0);
        chk("rst_flush", 32'(if_id_flush0), 32'd1);
        chk("rst_fwd", 32'(fwd_a0), 32'd0);
        adv();
        reset = 1'b1;
        nop(0, 0); settle();
        chk("rel_ctl", 32'(ctl0), 32'h1F0);
        chk("rel_stall_cnt", 32'(stall0), 32'd0);
        chk("rel_flush_cnt", 32'(flush0), 32'd0);
        adv();

        // Five stall cycles: the 2-bit counter stops at 3.
        drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 1, 0, 0, 1); cyc();
        nop(0, 1); cyc();
        for (int i = 0; i < 5; i++) begin
            nop(0, 0); cyc();
        end
        nop(0, 1); settle();
        chk("sat_stall_cnt0", 32'(stall0), 32'd5);
        chk("sat_stall_cnt1", 32'(stall1), 32'd3);
        adv();

        // Random traffic; redirect is held while either EX is frozen.
        prev_redir = 1'b0;
        for (int i = 0; i < 800; i++) begin
            logic redir, mr;
            reset = ($urandom_range(99) != 0);
            if (act[0] == A_MS || act[0] == A_MC || act[1] == A_MS || act[1] == A_MC)
                redir = prev_redir;
            else
                redir = ($urandom_range(5) == 0);
            mr = ($urandom_range(3) == 0);
            drive($urandom_range(3) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(3)),
                  1'($urandom_range(1)), mr, !mr && ($urandom_range(4) == 0),
                  $urandom_range(7) == 0, redir, $urandom_range(3) != 0);
            prev_redir = redir;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
